pipeline_wb_stage: RTL and testbench
====================================

# pipeline_wb_stage

Registered MEM/WB boundary plus write-back selection for the pipelined CPU. It captures the memory-stage bundle, aligns and extends load data, and selects among ALU, load, PC+4 and immediate results. It drives the register-file write port and the forwarding path, and keeps a retired-instruction counter. It sits between the data-memory interface and the register file, and replaces the purely combinational write-back mux.

## Interface
Parameters:
- XLEN, 32, datapath width; must be 32 when load extension is compiled in.
- RA_W, 5, register address width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold the MEM/WB register.
- flush_i  in  1  invalidate the MEM/WB register.
- valid_in  in  1  the MEM bundle is a real instruction.
- RegWrite_in  in  1  the instruction writes rd.
- MemtoReg_in  in  2  result select: 0 ALU, 1 load data, 2 PC+4, 3 immediate.
- rd_in  in  RA_W  destination register.
- ALU_in, DMem_data_in, PC4_in, imm_in  in  XLEN  candidate results; DMem_data_in is the raw aligned word.
- funct3_in  in  3  load type.
- addr_lo_in  in  2  byte offset of the load address.
- rf_we_o  out  1  register-file write enable.
- rf_wa_o  out  RA_W  write address.
- rf_wd_o  out  XLEN  write data; also the forwarding data.
- wb_valid_o  out  1  the WB slot holds a valid instruction.
- misalign_o  out  1  the current WB load is misaligned.
- retired_o  out  CNT_W  retired-instruction count.

## Operation
- MEM/WB register: holds all `*_in` fields plus the valid bit.
  - Priority at each rising edge: rst > flush_i > stall_i > load.
  - flush_i: clears the valid bit and leaves the data fields as don't-care.
  - stall_i without flush_i: the register holds its contents.
- Select: rf_wd_o is a combinational function of the registered fields only. MemtoReg 1 uses the extended load value.
- Load extension (MemtoReg 1), byte lane = addr_lo:
  - funct3 000 LB and 100 LBU: byte sign- or zero-extended.
  - funct3 001 LH and 101 LHU: halfword at offset {addr_lo[1],0}, sign- or zero-extended.
  - funct3 010 LW and any other code: full word.
- Misalignment:
  - misalign_o = valid & MemtoReg==1 & ((LH/LHU & addr_lo[0]) | (LW & addr_lo!=0)).
  - A misaligned load suppresses the register write.
- Write enable: rf_we_o = valid & RegWrite & (rd!=0) & !misalign_o.
- rf_wa_o: the registered rd.
- Retire counter:
  - Increments by 1 on an edge where wb_valid_o=1 and (stall_i=0 or flush_i=1), so each instruction is counted exactly once.
  - Wraps modulo 2^CNT_W.
  - Misaligned loads still count as retired.
- Reset values: every register is 0, so rf_we_o=0, rf_wa_o=0, rf_wd_o=0, wb_valid_o=0, misalign_o=0, retired_o=0.

## Timing
- Latency: a bundle presented at edge N (with stall_i=0) drives rf_* outputs from edge N until the next load edge.
- The register file writes at the edge following presentation, or on negedge per the regfile's own convention.
- During a stall, rf_we_o stays asserted with identical data; rewriting the same value is harmless.
- flush_i and stall_i together: flush wins; the outgoing valid instruction is counted as retired.
- Reset mid-instruction: outputs clear immediately and asynchronously; the in-flight write is lost.
- Outputs have no combinational path from any `*_in` port.

## Configuration
- WB_LOAD_EXT_EN defined:
  - Byte and halfword extraction and extension are implemented as above.
  - misalign_o is active.
- WB_LOAD_EXT_EN undefined:
  - MemtoReg 1 passes DMem_data_in unchanged.
  - misalign_o is tied to 0.
  - funct3_in and addr_lo_in are ignored.

## Test plan
- Reset, then one edge with valid_in=1, MemtoReg=0, ALU_in=0x12345678, rd=5, RegWrite=1 -> rf_we_o=1, rf_wa_o=5, rf_wd_o=0x12345678; after the next unstalled edge, retired_o=1.
- LB with DMem=0x80FF7F01: addr_lo=3 -> 0xFFFFFF80; LBU with addr_lo=1 -> 0x0000007F; LH with addr_lo=2 -> 0xFFFF80FF.
- LW with addr_lo=2 -> misalign_o=1, rf_we_o=0; retired_o still increments.
- Stall for 3 cycles, then release -> outputs stable for 3 cycles and retired_o increments once. Flush during the stall -> wb_valid_o=0 next cycle.
- rd=0 with RegWrite=1 and MemtoReg=2, PC4=0x104 -> rf_wd_o=0x104, rf_we_o=0.
- Assert rst asynchronously mid-cycle while wb_valid_o=1 -> all outputs 0 before the next edge. Separately, with CNT_W=4, 16 retirements from reset -> retired_o wraps to 0.

Source files
------------

// File: rtl/pipeline_wb_stage.sv
// -----------------------------------------------------------------------------
// pipeline_wb_stage
//
// Purpose:
//   Registered MEM/WB boundary with write-back result selection. The
//   memory-stage bundle is captured on the rising clock edge. Load data is
//   aligned and extended, and one of ALU / load / PC+4 / immediate is chosen
//   as the write-back value. The block drives the register-file write port,
//   which doubles as the forwarding path, and counts retired instructions.
//   All outputs are functions of registered state only, so nothing on any
//   *_in port reaches an output combinationally.
//
// Configuration macro:
//   WB_LOAD_EXT_EN - when defined, byte/halfword extraction with sign/zero
//                    extension and misalignment detection are built in.
//                    XLEN must then be 32. When undefined, MemtoReg==1
//                    passes DMem_data_in through unchanged. misalign_o is
//                    tied low, and funct3_in / addr_lo_in are ignored.
//
// Parameters:
//   XLEN  - datapath width
//   RA_W  - register address width
//   CNT_W - retired-instruction counter width (wraps modulo 2^CNT_W)
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   stall_i, flush_i  - hold / invalidate the MEM/WB register (flush wins)
//   valid_in          - MEM bundle is a real instruction
//   RegWrite_in       - instruction writes rd
//   MemtoReg_in       - 0 ALU, 1 load data, 2 PC+4, 3 immediate
//   rd_in             - destination register
//   ALU_in, DMem_data_in, PC4_in, imm_in - candidate results
//   funct3_in         - load type
//   addr_lo_in        - byte offset of the load address
//   rf_we_o, rf_wa_o, rf_wd_o - register-file write port / forwarding data
//   wb_valid_o        - WB slot holds a valid instruction
//   misalign_o        - current WB load is misaligned (write suppressed)
//   retired_o         - retired-instruction count
// -----------------------------------------------------------------------------
module pipeline_wb_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             valid_in,
    input  logic             RegWrite_in,
    input  logic [1:0]       MemtoReg_in,
    input  logic [RA_W-1:0]  rd_in,
    input  logic [XLEN-1:0]  ALU_in,
    input  logic [XLEN-1:0]  DMem_data_in,
    input  logic [XLEN-1:0]  PC4_in,
    input  logic [XLEN-1:0]  imm_in,
    input  logic [2:0]       funct3_in,
    input  logic [1:0]       addr_lo_in,
    output logic             rf_we_o,
    output logic [RA_W-1:0]  rf_wa_o,
    output logic [XLEN-1:0]  rf_wd_o,
    output logic             wb_valid_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_PC4  = 2'd2;
    localparam logic [1:0] SEL_IMM  = 2'd3;

    // -------------------------------------------------------------------------
    // MEM/WB register state
    // -------------------------------------------------------------------------
    logic             valid_q,     valid_d;
    logic             reg_write_q, reg_write_d;
    logic [1:0]       mem_to_reg_q, mem_to_reg_d;
    logic [RA_W-1:0]  rd_q,        rd_d;
    logic [XLEN-1:0]  alu_q,       alu_d;
    logic [XLEN-1:0]  dmem_q,      dmem_d;
    logic [XLEN-1:0]  pc4_q,       pc4_d;
    logic [XLEN-1:0]  imm_q,       imm_d;
    logic [CNT_W-1:0] retired_q,   retired_d;

`ifdef WB_LOAD_EXT_EN
    logic [2:0]       funct3_q,    funct3_d;
    logic [1:0]       addr_lo_q,   addr_lo_d;
`else
    // Load-type inputs have no effect in this build.
    logic             unused_ext_inputs;
    assign unused_ext_inputs = ^{funct3_in, addr_lo_in};
`endif

    // The slot leaves WB on any edge that is not a pure stall; a flush
    // evicts the current occupant, so it counts as leaving too.
    logic slot_advance;
    assign slot_advance = !stall_i || flush_i;

    always_comb begin
        // Data fields load whenever the register is not stalled. On a flush
        // their contents are don't-care because valid is cleared.
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        rd_d         = rd_q;
        alu_d        = alu_q;
        dmem_d       = dmem_q;
        pc4_d        = pc4_q;
        imm_d        = imm_q;
        if (!stall_i) begin
            reg_write_d  = RegWrite_in;
            mem_to_reg_d = MemtoReg_in;
            rd_d         = rd_in;
            alu_d        = ALU_in;
            dmem_d       = DMem_data_in;
            pc4_d        = PC4_in;
            imm_d        = imm_in;
        end

        // Priority: flush > stall > load.
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (stall_i) begin
            valid_d = valid_q;
        end else begin
            valid_d = valid_in;
        end

        // Each instruction is counted once, on the edge it leaves WB.
        retired_d = retired_q;
        if (valid_q && slot_advance) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

`ifdef WB_LOAD_EXT_EN
    always_comb begin
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        if (!stall_i) begin
            funct3_d  = funct3_in;
            addr_lo_d = addr_lo_in;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 2'd0;
            rd_q         <= '0;
            alu_q        <= '0;
            dmem_q       <= '0;
            pc4_q        <= '0;
            imm_q        <= '0;
            retired_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            rd_q         <= rd_d;
            alu_q        <= alu_d;
            dmem_q       <= dmem_d;
            pc4_q        <= pc4_d;
            imm_q        <= imm_d;
            retired_q    <= retired_d;
        end
    end

`ifdef WB_LOAD_EXT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct3_q  <= 3'd0;
            addr_lo_q <= 2'd0;
        end else begin
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Load alignment / extension
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] load_val;
    logic            misalign;

`ifdef WB_LOAD_EXT_EN
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic        is_half;
    logic        is_word;

    always_comb begin
        // Byte lane comes straight from addr_lo. The halfword lane ignores
        // addr_lo[0], so a misaligned halfword still yields a defined value.
        load_byte = dmem_q[{addr_lo_q, 3'b000} +: 8];
        load_half = dmem_q[{addr_lo_q[1], 4'b0000} +: 16];

        // funct3[2] selects zero extension for the unsigned variants.
        unique case (funct3_q)
            3'b000:  load_val = {{(XLEN-8){load_byte[7]}}, load_byte};
            3'b100:  load_val = {{(XLEN-8){1'b0}}, load_byte};
            3'b001:  load_val = {{(XLEN-16){load_half[15]}}, load_half};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, load_half};
            default: load_val = dmem_q;
        endcase

        is_half  = (funct3_q[1:0] == 2'b01);
        is_word  = (funct3_q == 3'b010);
        misalign = valid_q && (mem_to_reg_q == SEL_LOAD) &&
                   ((is_half && addr_lo_q[0]) || (is_word && (addr_lo_q != 2'd0)));
    end
`else
    assign load_val = dmem_q;
    assign misalign = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Write-back select and register-file port
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] wb_data;

    always_comb begin
        unique case (mem_to_reg_q)
            SEL_ALU:  wb_data = alu_q;
            SEL_LOAD: wb_data = load_val;
            SEL_PC4:  wb_data = pc4_q;
            SEL_IMM:  wb_data = imm_q;
            default:  wb_data = alu_q;
        endcase
    end

    // x0 is hard-wired, and a misaligned load must not corrupt rd.
    assign rf_we_o    = valid_q && reg_write_q && (rd_q != '0) && !misalign;
    assign rf_wa_o    = rd_q;
    assign rf_wd_o    = wb_data;
    assign wb_valid_o = valid_q;
    assign misalign_o = misalign;
    assign retired_o  = retired_q;

endmodule

// File: tb/tb_pipeline_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_pipeline_wb_stage
//
// Bench for pipeline_wb_stage. A second instance with CNT_W=4 shares all
// inputs so that counter wrap can be observed alongside the main instance.
// The driver changes inputs 1 time unit after a falling edge and pushes the
// expected WB slot contents. The monitor samples on every falling edge and
// pops one entry whenever wb_valid_o is high.
// -----------------------------------------------------------------------------
module tb_pipeline_wb_stage;

`ifdef WB_LOAD_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    localparam logic [31:0] DM = 32'h80FF7F01;

    logic        clk;
    logic        rst;
    logic        stall_i, flush_i, valid_in, reg_write_in;
    logic [1:0]  mem_to_reg_in;
    logic [4:0]  rd_in;
    logic [31:0] alu_in, dmem_in, pc4_in, imm_in;
    logic [2:0]  funct3_in;
    logic [1:0]  addr_lo_in;

    logic        rf_we_o, wb_valid_o, misalign_o;
    logic [4:0]  rf_wa_o;
    logic [31:0] rf_wd_o, retired_o;

    logic        we4, valid4, mis4;
    logic [4:0]  wa4;
    logic [31:0] wd4;
    logic [3:0]  retired4;

    pipeline_wb_stage #(.XLEN(32), .RA_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .valid_in(valid_in), .RegWrite_in(reg_write_in), .MemtoReg_in(mem_to_reg_in),
        .rd_in(rd_in), .ALU_in(alu_in), .DMem_data_in(dmem_in), .PC4_in(pc4_in),
        .imm_in(imm_in), .funct3_in(funct3_in), .addr_lo_in(addr_lo_in),
        .rf_we_o(rf_we_o), .rf_wa_o(rf_wa_o), .rf_wd_o(rf_wd_o),
        .wb_valid_o(wb_valid_o), .misalign_o(misalign_o), .retired_o(retired_o)
    );

    pipeline_wb_stage #(.XLEN(32), .RA_W(5), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .valid_in(valid_in), .RegWrite_in(reg_write_in), .MemtoReg_in(mem_to_reg_in),
        .rd_in(rd_in), .ALU_in(alu_in), .DMem_data_in(dmem_in), .PC4_in(pc4_in),
        .imm_in(imm_in), .funct3_in(funct3_in), .addr_lo_in(addr_lo_in),
        .rf_we_o(we4), .rf_wa_o(wa4), .rf_wd_o(wd4),
        .wb_valid_o(valid4), .misalign_o(mis4), .retired_o(retired4)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model of the WB slot.
    logic        m_valid;
    logic        m_we, m_mis;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (wb_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got wb_valid_o=1 expected no instruction at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("rf_we",      {31'd0, rf_we_o},    {31'd0, e.we});
                chk("rf_wa",      {27'd0, rf_wa_o},    {27'd0, e.wa});
                chk("rf_wd",      rf_wd_o,             e.wd);
                chk("misalign",   {31'd0, misalign_o}, {31'd0, e.mis});
                chk("retired",    retired_o,           e.cnt);
                chk("valid4",     {31'd0, valid4},     32'd1);
                chk("rf_we4",     {31'd0, we4},        {31'd0, e.we});
                chk("rf_wa4",     {27'd0, wa4},        {27'd0, e.wa});
                chk("rf_wd4",     wd4,                 e.wd);
                chk("misalign4",  {31'd0, mis4},       {31'd0, e.mis});
                chk("retired4",   {28'd0, retired4},   {28'd0, e.cnt[3:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Apply one cycle of inputs, advance the model across the next rising
    // edge, then return 1 time unit after the following falling edge.
    task automatic step(input logic st, input logic fl, input logic vin, input logic rw,
                        input logic [1:0] mtr, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] dm,
                        input logic [31:0] pc4, input logic [31:0] imm,
                        input logic [2:0] f3, input logic [1:0] alo,
                        input logic [31:0] exp_wd, input logic exp_mis);
        stall_i = st;  flush_i = fl;  valid_in = vin;  reg_write_in = rw;
        mem_to_reg_in = mtr;  rd_in = rd;  alu_in = alu;  dmem_in = dm;
        pc4_in = pc4;  imm_in = imm;  funct3_in = f3;  addr_lo_in = alo;

        if (m_valid && (!st || fl)) m_cnt = m_cnt + 32'd1;
        if (fl) begin
            m_valid = 1'b0;
        end else if (!st) begin
            m_valid = vin;
            m_we    = vin && rw && (rd != 5'd0) && !exp_mis;
            m_wa    = rd;
            m_wd    = exp_wd;
            m_mis   = exp_mis;
        end
        if (m_valid) exp_q.push_back('{we: m_we, wa: m_wa, wd: m_wd, mis: m_mis, cnt: m_cnt});
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic rw, input logic [1:0] mtr, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] dm,
                         input logic [31:0] pc4, input logic [31:0] imm,
                         input logic [2:0] f3, input logic [1:0] alo,
                         input logic [31:0] exp_wd, input logic exp_mis);
        step(1'b0, 1'b0, 1'b1, rw, mtr, rd, alu, dm, pc4, imm, f3, alo, exp_wd, exp_mis);
    endtask

    // Load from DM; ext_wd/ext_mis are the hand-computed results with
    // extension built in, otherwise the raw word is written and never flagged.
    task automatic load(input logic [2:0] f3, input logic [1:0] alo,
                        input logic [31:0] ext_wd, input logic ext_mis);
        issue(1'b1, 2'd1, 5'd10, 32'hDEAD0001, DM, 32'h0000_0200, 32'h0000_0ABC, f3, alo,
              EXT ? ext_wd : DM, EXT ? ext_mis : 1'b0);
    endtask

    // Stalled cycle: inputs carry a different bundle that must not be captured.
    task automatic stall_cycle(input logic fl);
        step(1'b1, fl, 1'b1, 1'b1, 2'd0, 5'd31, 32'hBAD0BAD0, 32'd0, 32'd0, 32'd0,
             3'd0, 2'd0, 32'hBAD0BAD0, 1'b0);
    endtask

    task automatic idle_cycle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0,
             3'd0, 2'd0, 32'd0, 1'b0);
    endtask

    task automatic check_idle(input string name);
        chk({name, "_valid"},    {31'd0, wb_valid_o}, 32'd0);
        chk({name, "_we"},       {31'd0, rf_we_o},    32'd0);
        chk({name, "_mis"},      {31'd0, misalign_o}, 32'd0);
        chk({name, "_retired"},  retired_o,           m_cnt);
        chk({name, "_retired4"}, {28'd0, retired4},   {28'd0, m_cnt[3:0]});
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_valid"},    {31'd0, wb_valid_o}, 32'd0);
        chk({name, "_we"},       {31'd0, rf_we_o},    32'd0);
        chk({name, "_wa"},       {27'd0, rf_wa_o},    32'd0);
        chk({name, "_wd"},       rf_wd_o,             32'd0);
        chk({name, "_mis"},      {31'd0, misalign_o}, 32'd0);
        chk({name, "_retired"},  retired_o,           32'd0);
        chk({name, "_retired4"}, {28'd0, retired4},   32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        stall_i = 1'b0;  flush_i = 1'b0;  valid_in = 1'b0;  reg_write_in = 1'b0;
        mem_to_reg_in = 2'd0;  rd_in = 5'd0;  alu_in = '0;  dmem_in = '0;
        pc4_in = '0;  imm_in = '0;  funct3_in = 3'd0;  addr_lo_in = 2'd0;
        m_valid = 1'b0;  m_we = 1'b0;  m_mis = 1'b0;  m_wa = '0;  m_wd = '0;  m_cnt = '0;

        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Basic ALU write, then retirement visible after the next free edge.
        issue(1'b1, 2'd0, 5'd5, 32'h12345678, 32'd0, 32'd0, 32'd0, 3'd0, 2'd0,
              32'h12345678, 1'b0);
        idle_cycle();
        check_idle("after_alu");

        // Load extension vectors, DM = 0x80FF7F01.
        load(3'b000, 2'd3, 32'hFFFFFF80, 1'b0);  // LB  byte 0x80
        load(3'b100, 2'd1, 32'h0000007F, 1'b0);  // LBU byte 0x7F
        load(3'b001, 2'd2, 32'hFFFF80FF, 1'b0);  // LH  half 0x80FF
        load(3'b101, 2'd2, 32'h000080FF, 1'b0);  // LHU half 0x80FF
        load(3'b000, 2'd1, 32'h0000007F, 1'b0);  // LB  positive byte
        load(3'b100, 2'd2, 32'h000000FF, 1'b0);  // LBU byte 0xFF
        load(3'b001, 2'd0, 32'h00007F01, 1'b0);  // LH  low half
        load(3'b010, 2'd0, 32'h80FF7F01, 1'b0);  // LW aligned
        load(3'b110, 2'd0, 32'h80FF7F01, 1'b0);  // other code -> full word
        load(3'b010, 2'd2, 32'h80FF7F01, 1'b1);  // LW misaligned
        load(3'b001, 2'd1, 32'h00007F01, 1'b1);  // LH odd offset
        load(3'b101, 2'd3, 32'h000080FF, 1'b1);  // LHU odd offset
        idle_cycle();
        check_idle("after_loads");

        // Non-load selects.
        issue(1'b1, 2'd2, 5'd0, 32'd0, 32'd0, 32'h00000104, 32'd0, 3'd0, 2'd0,
              32'h00000104, 1'b0);                                 // rd=0, PC+4
        issue(1'b1, 2'd3, 5'd7, 32'd1, 32'd2, 32'd3, 32'hFFFFF800, 3'd0, 2'd0,
              32'hFFFFF800, 1'b0);                                 // immediate
        issue(1'b0, 2'd0, 5'd9, 32'hCAFEF00D, 32'd0, 32'd0, 32'd0, 3'd0, 2'd0,
              32'hCAFEF00D, 1'b0);                                 // RegWrite=0
        issue(1'b1, 2'd1, 5'd3, 32'd0, 32'h13572468, 32'd0, 32'd0, 3'd0, 2'd0,
              EXT ? 32'h00000068 : 32'h13572468, 1'b0);            // LB lane 0

        // Stall three cycles: slot held, counted once on release.
        issue(1'b1, 2'd0, 5'd12, 32'hA5A5A5A5, 32'd0, 32'd0, 32'd0, 3'd0, 2'd0,
              32'hA5A5A5A5, 1'b0);
        stall_cycle(1'b0);
        stall_cycle(1'b0);
        stall_cycle(1'b0);
        idle_cycle();
        check_idle("after_stall");

        // Flush during a stall: slot invalid next cycle, still retired once.
        issue(1'b1, 2'd0, 5'd13, 32'h0F0F0F0F, 32'd0, 32'd0, 32'd0, 3'd0, 2'd0,
              32'h0F0F0F0F, 1'b0);
        stall_cycle(1'b0);
        stall_cycle(1'b1);
        check_idle("after_flush");

        // Flush without stall drops the incoming bundle.
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 5'd14, 32'h11111111, 32'd0, 32'd0, 32'd0,
             3'd0, 2'd0, 32'h11111111, 1'b0);
        check_idle("flush_incoming");

        // Asynchronous reset between edges while a write is in flight.
        issue(1'b1, 2'd0, 5'd15, 32'h55AA55AA, 32'd0, 32'd0, 32'd0, 3'd0, 2'd0,
              32'h55AA55AA, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        m_valid = 1'b0;
        m_cnt   = '0;
        exp_q.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Sixteen retirements from reset: the 4-bit counter wraps to 0.
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 2'd0, 5'(i + 1), 32'h100 + 32'(i), 32'd0, 32'd0, 32'd0, 3'd0, 2'd0,
                  32'h100 + 32'(i), 1'b0);
        end
        idle_cycle();
        check_idle("wrap");
        chk("wrap_retired4_zero", {28'd0, retired4}, 32'd0);
        chk("wrap_retired_16",    retired_o,         32'd16);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
